// File: rtl/sa_stream_pkg.sv
// sa_stream_pkg: shared types and helpers for the operand streamer.
// Holds the FSM state enum, counter widths and the wrapped index add.
package sa_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_t;

  localparam int CNT_W = 16;
  localparam int IDX_W = 32;

  // a + b modulo m, given a < m and b <= m.
  // One conditional subtract is enough under those bounds.
  function automatic logic [IDX_W-1:0] wrap_add(
    input logic [IDX_W-1:0] a,
    input logic [IDX_W-1:0] b,
    input logic [IDX_W-1:0] m
  );
    logic [IDX_W-1:0] s;
    s = a + b;
    return (s >= m) ? (s - m) : s;
  endfunction

endpackage

// File: rtl/sa_skew_line.sv
// sa_skew_line: DEPTH-stage WIDTH-bit delay line with enable and clear.
// Ports: i_clk, i_rst (async high), i_en shift, i_clr zero all, i_d in,
// o_q = input from DEPTH enabled shifts ago (DEPTH 0 = wire).
module sa_skew_line #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  if (DEPTH == 0) begin : g_wire
    assign o_q = i_d;
  end else begin : g_reg
    logic [WIDTH-1:0] r_sh [DEPTH];

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        for (int k = 0; k < DEPTH; k++)
          r_sh[k] <= '0;
      end else if (i_clr) begin
        for (int k = 0; k < DEPTH; k++)
          r_sh[k] <= '0;
      end else if (i_en) begin
        r_sh[0] <= i_d;
        for (int k = 1; k < DEPTH; k++)
          r_sh[k] <= r_sh[k-1];
      end
    end

    // Tap read before the shift: the value loaded DEPTH beats ago.
    assign o_q = r_sh[DEPTH-1];
  end

endmodule

// File: rtl/sa_operand_streamer.sv
// sa_operand_streamer: A/B operand buffers streamed onto AA/BB lanes.
// Ports: write port (wr_*), run control (start/len/beats/loop/stop),
// status (busy/done), lane buses AA/BB with out_valid/out_ready.
module sa_operand_streamer
  import sa_stream_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int HPE   = 4,
  parameter  int VPE   = 4,
  parameter  int DEPTH = 1024,
  parameter  int SKEW  = 1,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 wr_en,
  input  logic                 wr_sel,
  input  logic [AW-1:0]        wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 start,
  input  logic [AW:0]          len,
  input  logic [15:0]          beats,
  input  logic                 loop,
  input  logic                 stop,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH*HPE-1:0] AA,
  output logic [WIDTH*VPE-1:0] BB,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int LMAX = (HPE > VPE) ? HPE : VPE;
  localparam int D    = LMAX - 1;
  localparam bit DRN  = (SKEW != 0) && (D > 0);

  logic [WIDTH-1:0] r_mem_a [DEPTH];
  logic [WIDTH-1:0] r_mem_b [DEPTH];

  state_t               r_state;
  logic [AW-1:0]        r_ka;
  logic [AW-1:0]        r_kb;
  logic [AW:0]          r_len;
  logic [CNT_W-1:0]     r_beats;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     r_fl;
  logic                 r_loop;
  logic                 r_stop;
  logic                 r_valid;
  logic                 r_done;
  logic [WIDTH*HPE-1:0] r_aa;
  logic [WIDTH*VPE-1:0] r_bb;

  logic                 w_idle;
  logic                 w_go;
  logic                 w_acc;
  logic                 w_last;
  logic                 w_end;
  logic                 w_load;
  logic                 w_zero;
  logic [AW:0]          w_len;
  logic [AW-1:0]        w_ka;
  logic [AW-1:0]        w_kb;
  logic [CNT_W-1:0]     w_cnt_inc;
  logic [WIDTH*HPE-1:0] w_aa_nxt;
  logic [WIDTH*VPE-1:0] w_bb_nxt;

  assign w_idle = (r_state == ST_IDLE);

  assign w_go = w_idle && start
             && (len >= (AW+1)'(LMAX))
             && (loop || (beats != '0));

  assign w_acc     = r_valid && out_ready;
  assign w_cnt_inc = r_cnt + CNT_W'(1);

  // A stop seen in this cycle or latched earlier ends on this beat.
  assign w_last = (r_state == ST_RUN) && w_acc
               && (stop || r_stop
                   || (!r_loop && (w_cnt_inc == r_beats)));

  assign w_end = (w_last && !DRN)
              || ((r_state == ST_DRAIN) && w_acc
                  && (r_fl == CNT_W'(D - 1)));

  assign w_load = w_go || (w_acc && !w_end);

  // The beat being loaded is a flush beat: zeros into the lanes.
  assign w_zero = (r_state == ST_DRAIN) || w_last;

  // Base index of the beat being loaded (0 for the first beat).
  assign w_len = w_idle ? len : r_len;

  assign w_ka = w_idle ? '0 :
    AW'(wrap_add(IDX_W'(r_ka), IDX_W'(HPE), IDX_W'(w_len)));

  assign w_kb = w_idle ? '0 :
    AW'(wrap_add(IDX_W'(r_kb), IDX_W'(VPE), IDX_W'(w_len)));

  for (genvar i = 0; i < HPE; i++) begin : g_a
    logic [AW-1:0]    w_ix;
    logic [WIDTH-1:0] w_in;
    logic [WIDTH-1:0] w_sk;

    assign w_ix = AW'(wrap_add(IDX_W'(w_ka), IDX_W'(i),
                               IDX_W'(w_len)));
    assign w_in = w_zero ? '0 : r_mem_a[w_ix];

    if ((SKEW != 0) && (i > 0)) begin : g_sk
      sa_skew_line #(
        .WIDTH (WIDTH),
        .DEPTH (i)
      ) u_skew (
        .i_clk (CLK),
        .i_rst (RST),
        .i_en  (w_load),
        .i_clr (w_end),
        .i_d   (w_in),
        .o_q   (w_sk)
      );
    end else begin : g_wire
      assign w_sk = w_in;
    end

    assign w_aa_nxt[i*WIDTH +: WIDTH] = w_sk;
  end

  for (genvar j = 0; j < VPE; j++) begin : g_b
    logic [AW-1:0]    w_ix;
    logic [WIDTH-1:0] w_in;
    logic [WIDTH-1:0] w_sk;

    assign w_ix = AW'(wrap_add(IDX_W'(w_kb), IDX_W'(j),
                               IDX_W'(w_len)));
    assign w_in = w_zero ? '0 : r_mem_b[w_ix];

    if ((SKEW != 0) && (j > 0)) begin : g_sk
      sa_skew_line #(
        .WIDTH (WIDTH),
        .DEPTH (j)
      ) u_skew (
        .i_clk (CLK),
        .i_rst (RST),
        .i_en  (w_load),
        .i_clr (w_end),
        .i_d   (w_in),
        .o_q   (w_sk)
      );
    end else begin : g_wire
      assign w_sk = w_in;
    end

    assign w_bb_nxt[j*WIDTH +: WIDTH] = w_sk;
  end

  // Operand buffers: no reset, writable only while idle.
  always_ff @(posedge CLK) begin
    if (wr_en && w_idle) begin
      if (wr_sel)
        r_mem_b[wr_addr] <= wr_data;
      else
        r_mem_a[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_ka    <= '0;
      r_kb    <= '0;
      r_len   <= '0;
      r_beats <= '0;
      r_cnt   <= '0;
      r_fl    <= '0;
      r_loop  <= 1'b0;
      r_stop  <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_aa    <= '0;
      r_bb    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_go) begin
            r_state <= ST_RUN;
            r_len   <= len;
            r_beats <= beats;
            r_loop  <= loop;
            r_ka    <= '0;
            r_kb    <= '0;
            r_cnt   <= '0;
            r_fl    <= '0;
            r_stop  <= 1'b0;
            r_valid <= 1'b1;
            r_aa    <= w_aa_nxt;
            r_bb    <= w_bb_nxt;
          end
        end
        ST_RUN: begin
          if (stop)
            r_stop <= 1'b1;
          if (w_acc) begin
            r_ka  <= w_ka;
            r_kb  <= w_kb;
            r_cnt <= w_cnt_inc;
            if (w_end) begin
              r_state <= ST_IDLE;
              r_stop  <= 1'b0;
              r_valid <= 1'b0;
              r_done  <= 1'b1;
              r_aa    <= '0;
              r_bb    <= '0;
            end else begin
              r_aa <= w_aa_nxt;
              r_bb <= w_bb_nxt;
              if (w_last) begin
                r_state <= ST_DRAIN;
                r_stop  <= 1'b0;
              end
            end
          end
        end
        ST_DRAIN: begin
          if (w_acc) begin
            if (w_end) begin
              r_state <= ST_IDLE;
              r_valid <= 1'b0;
              r_done  <= 1'b1;
              r_aa    <= '0;
              r_bb    <= '0;
            end else begin
              r_fl <= r_fl + CNT_W'(1);
              r_aa <= w_aa_nxt;
              r_bb <= w_bb_nxt;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = !w_idle;
  assign done      = r_done;
  assign out_valid = r_valid;
  assign AA        = r_aa;
  assign BB        = r_bb;

endmodule

// File: tb/tb_sa_operand_streamer.sv
// tb_sa_operand_streamer: randomized streamer bench with a beat model.
// Drives a SKEW=0 and a SKEW=1 instance and scores every lane beat.
module tb_sa_operand_streamer;

  localparam int DLY = 3;

  logic         CLK;
  logic         RST;
  logic         wen [2];
  logic         wsel;
  logic [3:0]   waddr;
  logic [31:0]  wdata;
  logic         st [2];
  logic [4:0]   len;
  logic [15:0]  beats;
  logic         lp;
  logic         stp [2];
  logic         rdy [2];
  logic         bsy [2];
  logic         dn [2];
  logic         ov [2];
  logic [127:0] aa [2];
  logic [127:0] bb [2];

  logic [31:0] mem [2][2][16];

  int n_chk;
  int n_fail;

  sa_operand_streamer #(
    .WIDTH(32), .HPE(4), .VPE(4), .DEPTH(16), .SKEW(0)
  ) u_dut0 (
    .CLK(CLK), .RST(RST),
    .wr_en(wen[0]), .wr_sel(wsel),
    .wr_addr(waddr), .wr_data(wdata),
    .start(st[0]), .len(len), .beats(beats),
    .loop(lp), .stop(stp[0]),
    .busy(bsy[0]), .done(dn[0]),
    .AA(aa[0]), .BB(bb[0]),
    .out_valid(ov[0]), .out_ready(rdy[0])
  );

  sa_operand_streamer #(
    .WIDTH(32), .HPE(4), .VPE(4), .DEPTH(16), .SKEW(1)
  ) u_dut1 (
    .CLK(CLK), .RST(RST),
    .wr_en(wen[1]), .wr_sel(wsel),
    .wr_addr(waddr), .wr_data(wdata),
    .start(st[1]), .len(len), .beats(beats),
    .loop(lp), .stop(stp[1]),
    .busy(bsy[1]), .done(dn[1]),
    .AA(aa[1]), .BB(bb[1]),
    .out_valid(ov[1]), .out_ready(rdy[1])
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Beat m of a run: data beat n lane i holds buf[(n*4+i) mod len];
  // skewed lane i shows data beat m-i, zero outside 0..nd-1.
  function automatic logic [127:0] exp_vec(input int d, input int sel,
                                           input int m, input int ln,
                                           input int nd);
    logic [127:0] v;
    int src;
    v = '0;
    for (int i = 0; i < 4; i++) begin
      src = (d == 1) ? m - i : m;
      if (src >= 0 && (nd < 0 || src < nd))
        v[i*32 +: 32] = mem[d][sel][(src*4 + i) % ln];
    end
    return v;
  endfunction

  task automatic write_word(input int d, input int sel,
                            input int a, input logic [31:0] v);
    wen[d] = 1'b1;
    wsel   = sel[0];
    waddr  = 4'(a);
    wdata  = v;
    @(negedge CLK);
    wen[d] = 1'b0;
    mem[d][sel][a] = v;
  endtask

  task automatic run(input int d, input int ln, input int bt,
                     input bit lpm, input int stop_m,
                     input int stall_pct, input int stall_beat,
                     input int stall_n, input bit wr_busy);
    int  m;
    int  nd;
    int  cyc;
    int  nst;
    int  stl;
    int  tot;
    bit  sseen;
    bit  sdone;
    bit  r;
    bit  s;
    len   = 5'(ln);
    beats = 16'(bt);
    lp    = lpm;
    st[d] = 1'b1;
    @(negedge CLK);
    st[d] = 1'b0;
    chk("start_busy", 128'(bsy[d]), 128'(1));
    m = 0; nd = -1; cyc = 0; nst = 0;
    stl = stall_n; sseen = 0; sdone = 0;
    while (!dn[d] && cyc < 400) begin
      if (m == stall_beat && stl > 0) begin
        r = 1'b0;
        stl--;
      end else begin
        r = ($urandom_range(99) >= stall_pct);
      end
      s = 1'b0;
      if (nd < 0 && m == stop_m && !sdone) begin
        s = 1'b1;
        sdone = 1;
        sseen = 1;
      end
      chk("valid", 128'(ov[d]), 128'(1));
      chk("aa", aa[d], exp_vec(d, 0, m, ln, nd));
      chk("bb", bb[d], exp_vec(d, 1, m, ln, nd));
      if (r) begin
        if (nd < 0 && (sseen || (!lpm && m + 1 == bt)))
          nd = m + 1;
        m++;
      end else begin
        nst++;
      end
      rdy[d] = r;
      stp[d] = s;
      wen[d] = wr_busy && (cyc == 2);
      wsel   = 1'b0;
      waddr  = 4'd0;
      wdata  = 32'hDEAD;
      @(negedge CLK);
      cyc++;
    end
    stp[d] = 1'b0;
    wen[d] = 1'b0;
    rdy[d] = 1'b1;
    if (cyc >= 400)
      chk("timeout", 128'(0), 128'(1));
    tot = nd + ((d == 1) ? DLY : 0);
    chk("done", 128'(dn[d]), 128'(1));
    chk("beats", 128'(m), 128'(tot));
    chk("cycles", 128'(cyc), 128'(tot + nst));
    chk("end_busy", 128'(bsy[d]), 128'(0));
    chk("end_valid", 128'(ov[d]), 128'(0));
    chk("end_aa", aa[d], 128'(0));
    chk("end_bb", bb[d], 128'(0));
  endtask

  task automatic idle_chk(input int d);
    @(negedge CLK);
    chk("done_pulse", 128'(dn[d]), 128'(0));
    chk("idle_busy", 128'(bsy[d]), 128'(0));
  endtask

  initial begin
    int d;
    int ln;
    int bt;
    int sm;
    bit l;
    n_chk = 0;
    n_fail = 0;
    RST = 1'b1;
    wsel = 1'b0; waddr = '0; wdata = '0;
    len = '0; beats = '0; lp = 1'b0;
    for (int k = 0; k < 2; k++) begin
      wen[k] = 1'b0; st[k] = 1'b0;
      stp[k] = 1'b0; rdy[k] = 1'b1;
    end
    @(negedge CLK);
    for (int k = 0; k < 2; k++) begin
      chk("rst_busy", 128'(bsy[k]), 128'(0));
      chk("rst_done", 128'(dn[k]), 128'(0));
      chk("rst_valid", 128'(ov[k]), 128'(0));
      chk("rst_aa", aa[k], 128'(0));
      chk("rst_bb", bb[k], 128'(0));
    end
    RST = 1'b0;
    for (int a = 0; a < 16; a++) begin
      write_word(0, 0, a, 32'(a + 1));
      write_word(1, 0, a, 32'(a + 1));
      write_word(0, 1, a, 32'h100 + 32'(a));
      write_word(1, 1, a, 32'h100 + 32'(a));
    end

    run(0, 10, 3, 0, -1, 0, -1, 0, 0);
    idle_chk(0);
    run(0, 10, 3, 0, -1, 0, 1, 3, 0);
    idle_chk(0);
    run(1, 8, 2, 0, -1, 0, -1, 0, 0);
    idle_chk(1);
    run(0, 6, 2, 1, 4, 0, -1, 0, 0);
    idle_chk(0);

    len = 5'd10; beats = 16'd8; lp = 1'b0;
    rdy[0] = 1'b1; st[0] = 1'b1;
    @(negedge CLK);
    st[0] = 1'b0;
    @(negedge CLK);
    chk("pre_rst_busy", 128'(bsy[0]), 128'(1));
    RST = 1'b1;
    #1;
    chk("mid_rst_busy", 128'(bsy[0]), 128'(0));
    chk("mid_rst_valid", 128'(ov[0]), 128'(0));
    chk("mid_rst_aa", aa[0], 128'(0));
    chk("mid_rst_bb", bb[0], 128'(0));
    @(negedge CLK);
    chk("mid_rst_done", 128'(dn[0]), 128'(0));
    RST = 1'b0;
    len = 5'd3; st[0] = 1'b1;
    @(negedge CLK);
    st[0] = 1'b0;
    chk("short_len", 128'(bsy[0]), 128'(0));
    len = 5'd10; beats = 16'd0; lp = 1'b0; st[0] = 1'b1;
    @(negedge CLK);
    st[0] = 1'b0;
    chk("zero_beats", 128'(bsy[0]), 128'(0));
    run(0, 10, 4, 0, -1, 20, -1, 0, 0);
    idle_chk(0);

    run(0, 8, 6, 0, -1, 0, -1, 0, 1);
    idle_chk(0);
    run(0, 8, 2, 0, -1, 0, -1, 0, 0);
    idle_chk(0);
    write_word(0, 0, 0, 32'hDEAD);
    run(0, 8, 2, 0, -1, 0, -1, 0, 0);
    chk("idle_wr", 128'(mem[0][0][0]), 128'(32'hDEAD));
    write_word(0, 0, 0, 32'd1);

    for (int r = 0; r < 16; r++) begin
      d  = int'($urandom_range(1));
      ln = int'($urandom_range(16, 4));
      bt = int'($urandom_range(12, 1));
      l  = 1'($urandom_range(1));
      if (l)
        sm = int'($urandom_range(10));
      else if ($urandom_range(3) == 0)
        sm = int'($urandom_range(bt - 1));
      else
        sm = -1;
      run(d, ln, bt, l, sm, 30, -1, 0, 0);
      if ($urandom_range(1) == 1)
        idle_chk(d);
    end
    idle_chk(0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
